// File: rtl/race_score_fsm.sv
// Score engine for the press-the-correct-box race game: global start/run/win FSM plus one
// press FSM per player, each keeping a BCD score with a binary shadow for the win compare.
module race_score_fsm #(
  parameter int unsigned NUM_PLAYERS  = 2,
  parameter int unsigned NUM_DIGITS   = 2,
  parameter int unsigned WIN_SCORE    = 20,
  parameter int unsigned PENALTY_MODE = 0,
  parameter int unsigned LOCK_CYCLES  = 8
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                start,
  input  logic [NUM_PLAYERS-1:0]              key_l,
  input  logic [NUM_PLAYERS-1:0]              key_r,
  input  logic [NUM_PLAYERS-1:0]              box_dir,
  output logic [NUM_PLAYERS-1:0]              box_ack,
  output logic [NUM_PLAYERS-1:0]              miss,
  output logic [NUM_PLAYERS*NUM_DIGITS*4-1:0] score_bcd,
  output logic                                running,
  output logic                                game_over,
  output logic [NUM_PLAYERS-1:0]              winner
);

  localparam int unsigned DigW = NUM_DIGITS * 4;
  localparam int unsigned BinW = $clog2(10 ** NUM_DIGITS);
  localparam int unsigned CntW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [BinW-1:0] WinVal = BinW'(WIN_SCORE);

  typedef enum logic [1:0] {GIdle, GRun, GEnd} g_state_e;
  typedef enum logic [1:0] {PReady, PHeld, PLock} p_state_e;

  g_state_e               g_q, g_d;
  p_state_e               p_q   [NUM_PLAYERS];
  p_state_e               p_d   [NUM_PLAYERS];
  logic [CntW-1:0]        cnt_q [NUM_PLAYERS];
  logic [CntW-1:0]        cnt_d [NUM_PLAYERS];
  logic [DigW-1:0]        bcd_q [NUM_PLAYERS];
  logic [DigW-1:0]        bcd_d [NUM_PLAYERS];
  logic [BinW-1:0]        bin_q [NUM_PLAYERS];
  logic [BinW-1:0]        bin_d [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] ack_q, ack_d, miss_q, miss_d, win_q, win_d, at_win;
  logic                   clear;

  function automatic logic [DigW-1:0] bcd_inc(input logic [DigW-1:0] v);
    logic [DigW-1:0] r;
    logic            c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < int'(NUM_DIGITS); d++) begin
      if (c) begin
        if (r[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [DigW-1:0] bcd_dec(input logic [DigW-1:0] v);
    logic [DigW-1:0] r;
    logic            b;
    r = v;
    b = 1'b1;
    for (int d = 0; d < int'(NUM_DIGITS); d++) begin
      if (b) begin
        if (r[d*4 +: 4] == 4'd0) begin
          r[d*4 +: 4] = 4'd9;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      g_q    <= GIdle;
      ack_q  <= '0;
      miss_q <= '0;
      win_q  <= '0;
      for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
        p_q[p]   <= PHeld;
        cnt_q[p] <= '0;
        bcd_q[p] <= '0;
        bin_q[p] <= '0;
      end
    end else begin
      g_q    <= g_d;
      ack_q  <= ack_d;
      miss_q <= miss_d;
      win_q  <= win_d;
      for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
        p_q[p]   <= p_d[p];
        cnt_q[p] <= cnt_d[p];
        bcd_q[p] <= bcd_d[p];
        bin_q[p] <= bin_d[p];
      end
    end
  end

  always_comb begin
    at_win = '0;
    for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
      at_win[p] = (bin_q[p] == WinVal);
    end
  end

  always_comb begin
    g_d   = g_q;
    win_d = win_q;
    clear = 1'b0;
    unique case (g_q)
      GIdle: begin
        if (start) begin
          g_d   = GRun;
          win_d = '0;
          clear = 1'b1;
        end
      end
      GRun: begin
        // Win beats abort so a final-cycle release of start still records the winner.
        if (|at_win) begin
          g_d   = GEnd;
          win_d = at_win;
        end else if (!start) begin
          g_d = GIdle;
        end
      end
      GEnd: begin
        if (!start) g_d = GIdle;
      end
      default: g_d = GIdle;
    endcase
  end

  always_comb begin
    ack_d  = '0;
    miss_d = '0;
    for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
      p_d[p]   = p_q[p];
      cnt_d[p] = cnt_q[p];
      bcd_d[p] = clear ? '0 : bcd_q[p];
      bin_d[p] = clear ? '0 : bin_q[p];
      if (g_q != GRun) begin
        p_d[p] = PHeld;
      end else begin
        unique case (p_q[p])
          PHeld: begin
            if (!key_l[p] && !key_r[p]) p_d[p] = PReady;
          end
          PReady: begin
            if (key_l[p] && key_r[p]) begin
              p_d[p] = PHeld;
            end else if (key_l[p] || key_r[p]) begin
              p_d[p] = PHeld;
              if (key_r[p] == box_dir[p]) begin
                ack_d[p] = 1'b1;
                bcd_d[p] = bcd_inc(bcd_q[p]);
                bin_d[p] = bin_q[p] + BinW'(1);
              end else begin
                miss_d[p] = 1'b1;
                if (PENALTY_MODE == 1 && bin_q[p] != '0) begin
                  bcd_d[p] = bcd_dec(bcd_q[p]);
                  bin_d[p] = bin_q[p] - BinW'(1);
                end else if (PENALTY_MODE == 2) begin
                  p_d[p]   = PLock;
                  cnt_d[p] = CntW'(LOCK_CYCLES - 1);
                end
              end
            end
          end
          PLock: begin
            if (cnt_q[p] == '0) p_d[p] = PHeld;
            else cnt_d[p] = cnt_q[p] - CntW'(1);
          end
          default: p_d[p] = PHeld;
        endcase
      end
    end
  end

  always_comb begin
    running   = (g_q == GRun);
    game_over = (g_q == GEnd);
    box_ack   = ack_q;
    miss      = miss_q;
    winner    = win_q;
    score_bcd = '0;
    for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
      score_bcd[p*DigW +: DigW] = bcd_q[p];
    end
  end

endmodule

// File: tb/tb_race_score_fsm.sv
// Directed bench for race_score_fsm: four instances (penalty modes 0/1/2 and a short game)
// share one stimulus stream; each check looks at the instance whose behaviour it targets.
module tb_race_score_fsm;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [1:0] key_l = '0, key_r = '0, box_dir = 2'b11;

  logic [1:0]  a0, m0, w0, a1, m1, w1, a2, m2, w2, a3, m3, w3;
  logic [15:0] s0, s1, s2, s3;
  logic        r0, g0, r1, g1, r2, g2, r3, g3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  race_score_fsm #(.PENALTY_MODE(0)) u0 (
    .clk(clk), .resetn(resetn), .start(start), .key_l(key_l), .key_r(key_r), .box_dir(box_dir),
    .box_ack(a0), .miss(m0), .score_bcd(s0), .running(r0), .game_over(g0), .winner(w0));
  race_score_fsm #(.PENALTY_MODE(1)) u1 (
    .clk(clk), .resetn(resetn), .start(start), .key_l(key_l), .key_r(key_r), .box_dir(box_dir),
    .box_ack(a1), .miss(m1), .score_bcd(s1), .running(r1), .game_over(g1), .winner(w1));
  race_score_fsm #(.PENALTY_MODE(2), .LOCK_CYCLES(8)) u2 (
    .clk(clk), .resetn(resetn), .start(start), .key_l(key_l), .key_r(key_r), .box_dir(box_dir),
    .box_ack(a2), .miss(m2), .score_bcd(s2), .running(r2), .game_over(g2), .winner(w2));
  race_score_fsm #(.WIN_SCORE(3)) u3 (
    .clk(clk), .resetn(resetn), .start(start), .key_l(key_l), .key_r(key_r), .box_dir(box_dir),
    .box_ack(a3), .miss(m3), .score_bcd(s3), .running(r3), .game_over(g3), .winner(w3));

  typedef struct {
    logic        st;
    logic [1:0]  kl, kr;
    logic [15:0] score;
    logic [1:0]  ack, miss;
    logic        run, go;
  } vec_t;

  vec_t vecs[14];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    start  = 1'b0;
    key_l  = '0;
    key_r  = '0;
    tick;
    resetn = 1'b1;
  endtask

  task automatic start_game;
    do_reset;
    start = 1'b1;
    tick;
    tick;
  endtask

  task automatic press(input logic [1:0] l, input logic [1:0] r);
    key_l = l;
    key_r = r;
    tick;
  endtask

  task automatic release_keys;
    key_l = '0;
    key_r = '0;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //         st  kl     kr     score     ack    miss   run   go
    vecs[0]  = '{1'b1, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b00, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b00, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 2'b00, 2'b01, 16'h0001, 2'b01, 2'b00, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 2'b00, 2'b01, 16'h0001, 2'b00, 2'b00, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 2'b00, 2'b01, 16'h0001, 2'b00, 2'b00, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 2'b00, 2'b00, 16'h0001, 2'b00, 2'b00, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 2'b01, 2'b00, 16'h0001, 2'b00, 2'b01, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 2'b00, 2'b00, 16'h0001, 2'b00, 2'b00, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 2'b01, 2'b01, 16'h0001, 2'b00, 2'b00, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 2'b00, 2'b00, 16'h0001, 2'b00, 2'b00, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 2'b00, 2'b11, 16'h0102, 2'b11, 2'b00, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 2'b00, 2'b00, 16'h0102, 2'b00, 2'b00, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 2'b10, 2'b00, 16'h0102, 2'b00, 2'b10, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 2'b00, 2'b00, 16'h0102, 2'b00, 2'b00, 1'b0, 1'b0};

    // Reset state
    tick;
    tick;
    chk("reset_u0", {s0, a0, m0, w0, r0, g0}, 32'h0);
    chk("reset_u2", {s2, a2, m2, w2, r2, g2}, 32'h0);
    resetn = 1'b1;

    // Table: start, correct press with hold, wrong press, double press, dual scoring, abort
    for (int i = 0; i < 14; i++) begin
      start = vecs[i].st;
      key_l = vecs[i].kl;
      key_r = vecs[i].kr;
      tick;
      chk($sformatf("vec%0d {score,ack,miss,run,go}", i), {s0, a0, m0, r0, g0},
          {vecs[i].score, vecs[i].ack, vecs[i].miss, vecs[i].run, vecs[i].go});
    end
    chk("abort_winner", {30'd0, w0}, 32'd0);

    // BCD carry 09 -> 10
    start_game;
    for (int i = 1; i <= 10; i++) begin
      press(2'b00, 2'b01);
      if (i == 9) chk("carry_09", {16'd0, s0}, 32'h0009);
      if (i == 10) chk("carry_ack", {30'd0, a0}, 32'd1);
      release_keys;
    end
    chk("carry_10", {16'd0, s0}, 32'h0010);
    chk("carry_still_running", {30'd0, r0, g0}, 32'h2);

    // Penalties after score 03
    start_game;
    for (int i = 0; i < 3; i++) begin
      press(2'b00, 2'b01);
      release_keys;
    end
    press(2'b01, 2'b00);
    chk("pen0_score_miss", {14'd0, s0, m0}, {14'd0, 16'h0003, 2'b01});
    chk("pen1_score_miss", {14'd0, s1, m1}, {14'd0, 16'h0002, 2'b01});
    chk("pen2_score_miss", {14'd0, s2, m2}, {14'd0, 16'h0003, 2'b01});
    key_l = '0;
    for (int i = 0; i < 8; i++) begin
      key_r = {1'b0, i[0]};
      tick;
      chk($sformatf("lock_ack_c%0d", i), {30'd0, a2}, 32'd0);
    end
    chk("lock_score", {16'd0, s2}, 32'h0003);
    key_r = 2'b00;
    tick;
    key_r = 2'b01;
    tick;
    chk("unlock_press", {14'd0, s2, a2}, {14'd0, 16'h0004, 2'b01});

    // Decrement floors at 00
    start_game;
    press(2'b01, 2'b00);
    chk("pen1_floor", {14'd0, s1, m1}, {14'd0, 16'h0000, 2'b01});
    release_keys;

    // Win and tie at WIN_SCORE=3
    start_game;
    for (int i = 0; i < 3; i++) begin
      press(2'b00, 2'b11);
      if (i == 2) chk("tie_scores", {16'd0, s3}, 32'h0303);
      release_keys;
    end
    chk("tie_end", {29'd0, w3, g3}, {29'd0, 2'b11, 1'b1});
    chk("tie_not_running", {31'd0, r3}, 32'd0);
    press(2'b00, 2'b11);
    release_keys;
    chk("frozen_scores", {16'd0, s3}, 32'h0303);
    chk("frozen_winner", {30'd0, w3}, 32'h3);

    // Restart with a key held across the start edge
    start = 1'b0;
    tick;
    chk("end_to_idle", {15'd0, s3, r3}, {15'd0, 16'h0303, 1'b0});
    key_r = 2'b01;
    start = 1'b1;
    tick;
    chk("restart_clear", {13'd0, s3, w3, r3}, {13'd0, 16'h0000, 2'b00, 1'b1});
    tick;
    tick;
    chk("held_key_no_score", {14'd0, s3, a3}, 32'h0);
    key_r = 2'b00;
    tick;
    key_r = 2'b01;
    tick;
    chk("repress_scores", {14'd0, s3, a3}, {14'd0, 16'h0001, 2'b01});
    key_r = 2'b00;
    start = 1'b0;
    tick;
    chk("abort_kept", {12'd0, s3, w3, r3, g3}, {12'd0, 16'h0001, 2'b00, 1'b0, 1'b0});

    // Asynchronous reset mid-game
    start_game;
    for (int i = 0; i < 15; i++) begin
      press(2'b00, 2'b01);
      release_keys;
    end
    chk("score_15", {16'd0, s0}, 32'h0015);
    press(2'b10, 2'b00);
    chk("lock_miss_p1", {30'd0, m2}, 32'h2);
    key_l = '0;
    start = 1'b0;
    #3;
    resetn = 1'b0;
    #1;
    chk("async_u0", {s0, a0, m0, w0, r0, g0}, 32'h0);
    chk("async_u2", {s2, a2, m2, w2, r2, g2}, 32'h0);
    tick;
    #2;
    resetn = 1'b1;
    tick;
    chk("post_reset_u2_a", {s2, a2, m2, w2, r2, g2}, 32'h0);
    tick;
    chk("post_reset_u2_b", {s2, a2, m2, w2, r2, g2}, 32'h0);
    chk("post_reset_u0", {s0, a0, m0, w0, r0, g0}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
